// File: rtl/simcomp_param.sv
`default_nettype none
// ============================================================================
//  Module   : simcomp_param
//  Brief    : Parametrised fetch/decode/execute accumulator core with flags,
//             halt/resume control and a program-load port.
//  Revision : 1.0
// ============================================================================
module simcomp_param #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 6,
    parameter int RESET_PC = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    input  logic              resume,
    output logic [ADDR_W-1:0] PC,
    output logic [DATA_W-1:0] IR,
    output logic [DATA_W-1:0] MBR,
    output logic [DATA_W-1:0] AC,
    output logic [ADDR_W-1:0] MAR,
    output logic              halted,
    output logic              zero,
    output logic              carry
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_OPER   = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] c_OP_AND   = 4'h1;
    localparam logic [3:0] c_OP_LOADI = 4'h2;
    localparam logic [3:0] c_OP_LOAD  = 4'h3;
    localparam logic [3:0] c_OP_SUB   = 4'h5;
    localparam logic [3:0] c_OP_ADD   = 4'h7;
    localparam logic [3:0] c_OP_JMP   = 4'h8;
    localparam logic [3:0] c_OP_JZ    = 4'h9;
    localparam logic [3:0] c_OP_STORE = 4'hB;
    localparam logic [3:0] c_OP_HALT  = 4'hF;

    localparam logic [ADDR_W-1:0] c_RESET_PC = RESET_PC[ADDR_W-1:0];

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_mbr;
    logic [DATA_W-1:0] r_ac;
    logic [ADDR_W-1:0] r_mar;
    logic              r_halted;
    logic              r_zero;
    logic              r_carry;
    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

    logic [3:0]        w_opcode;
    logic [ADDR_W-1:0] w_operand;
    logic [DATA_W-1:0] w_operand_ext;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_diff;
    logic [DATA_W-1:0] w_and;
    logic              w_borrow;
    logic              w_store_wb;
    logic              w_prog_ok;

    assign w_opcode      = r_ir[DATA_W-1 -: 4];
    assign w_operand     = r_ir[ADDR_W-1:0];
    assign w_operand_ext = {{(DATA_W-ADDR_W){1'b0}}, w_operand};
    assign w_sum         = {1'b0, r_ac} + {1'b0, r_mbr};
    assign w_diff        = r_ac - r_mbr;
    assign w_and         = r_ac & r_mbr;
    assign w_borrow      = (r_ac < r_mbr);
    // Reset aborts a STORE sitting in write-back.
    assign w_store_wb    = !reset && (r_state == S_WB) && (w_opcode == c_OP_STORE);
    assign w_prog_ok     = prog_we && (reset || (r_state == S_HALT));

    always_ff @(posedge clock) begin
        if (w_prog_ok) begin
            r_mem[prog_addr] <= prog_data;
        end else if (w_store_wb) begin
            r_mem[r_mar] <= r_mbr;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_FETCH;
            r_pc     <= c_RESET_PC;
            r_ir     <= '0;
            r_mbr    <= '0;
            r_ac     <= '0;
            r_mar    <= '0;
            r_halted <= 1'b0;
            r_zero   <= 1'b1;
            r_carry  <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    r_mar   <= r_pc;
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    r_ir    <= r_mem[r_mar];
                    r_pc    <= r_pc + 1'b1;
                    r_state <= S_OPER;
                end
                S_OPER: begin
                    r_mar <= w_operand;
                    case (w_opcode)
                        c_OP_JMP: begin
                            r_pc    <= w_operand;
                            r_state <= S_FETCH;
                        end
                        c_OP_JZ: begin
                            if (r_zero) begin
                                r_pc <= w_operand;
                            end
                            r_state <= S_FETCH;
                        end
                        c_OP_LOADI: begin
                            r_ac    <= w_operand_ext;
                            r_zero  <= (w_operand_ext == '0);
                            r_state <= S_FETCH;
                        end
                        c_OP_HALT: begin
                            r_halted <= 1'b1;
                            r_state  <= S_HALT;
                        end
                        c_OP_LOAD, c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_STORE: begin
                            r_state <= S_EXEC;
                        end
                        default: begin
                            r_state <= S_FETCH;
                        end
                    endcase
                end
                S_EXEC: begin
                    if (w_opcode == c_OP_STORE) begin
                        r_mbr <= r_ac;
                    end else begin
                        r_mbr <= r_mem[r_mar];
                    end
                    r_state <= S_WB;
                end
                S_WB: begin
                    case (w_opcode)
                        c_OP_LOAD: begin
                            r_ac   <= r_mbr;
                            r_zero <= (r_mbr == '0);
                        end
                        c_OP_ADD: begin
                            r_ac    <= w_sum[DATA_W-1:0];
                            r_carry <= w_sum[DATA_W];
                            r_zero  <= (w_sum[DATA_W-1:0] == '0);
                        end
                        c_OP_SUB: begin
                            r_ac    <= w_diff;
                            r_carry <= w_borrow;
                            r_zero  <= (w_diff == '0);
                        end
                        c_OP_AND: begin
                            r_ac   <= w_and;
                            r_zero <= (w_and == '0);
                        end
                        default: begin
                        end
                    endcase
                    r_state <= S_FETCH;
                end
                S_HALT: begin
                    // PC already points past the HALT, so resuming continues in sequence.
                    if (resume) begin
                        r_halted <= 1'b0;
                        r_state  <= S_FETCH;
                    end
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

    assign PC     = r_pc;
    assign IR     = r_ir;
    assign MBR    = r_mbr;
    assign AC     = r_ac;
    assign MAR    = r_mar;
    assign halted = r_halted;
    assign zero   = r_zero;
    assign carry  = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_simcomp_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_simcomp_param
//  Brief    : Directed bench for simcomp_param with an instruction-level model.
//  Revision : 1.0
// ============================================================================
module tb_simcomp_param;

    localparam int DW = 16;
    localparam int AW = 6;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [DW-1:0] prog_data = '0;
    logic          resume = 1'b0;
    logic          resume_w = 1'b0;

    logic [AW-1:0] PC, MAR;
    logic [DW-1:0] IR, MBR, AC;
    logic          halted, zero, carry;

    logic [AW-1:0] w_wrap_pc, w_wrap_mar;
    logic [DW-1:0] w_wrap_ir, w_wrap_mbr, w_wrap_ac;
    logic          w_wrap_halted, w_wrap_zero, w_wrap_carry;

    int n_checks = 0;
    int n_err    = 0;

    simcomp_param #(.DATA_W(DW), .ADDR_W(AW), .RESET_PC(10)) dut (
        .clock(clock), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .resume(resume), .PC(PC), .IR(IR), .MBR(MBR),
        .AC(AC), .MAR(MAR), .halted(halted), .zero(zero), .carry(carry)
    );

    simcomp_param #(.DATA_W(DW), .ADDR_W(AW), .RESET_PC(63)) dut_wrap (
        .clock(clock), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .resume(resume_w), .PC(w_wrap_pc), .IR(w_wrap_ir),
        .MBR(w_wrap_mbr), .AC(w_wrap_ac), .MAR(w_wrap_mar), .halted(w_wrap_halted),
        .zero(w_wrap_zero), .carry(w_wrap_carry)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- instruction-level model ----------------
    logic [DW-1:0] m_mem [0:(1<<AW)-1];
    logic [AW-1:0] m_pc;
    logic [DW-1:0] m_ir, m_mbr, m_ac;
    logic [AW-1:0] m_mar;
    logic          m_zero, m_carry, m_halted;
    logic          m_valid = 1'b0;
    int            m_cnt, m_lat;

    function automatic int latency(input logic [3:0] op);
        case (op)
            4'h1, 4'h3, 4'h5, 4'h7, 4'hB: return 5;
            default:                       return 3;
        endcase
    endfunction

    task automatic model_exec();
        logic [DW-1:0] inst;
        logic [AW-1:0] opd;
        logic [DW:0]   s;
        inst  = m_mem[m_pc];
        opd   = inst[AW-1:0];
        m_ir  = inst;
        m_pc  = m_pc + 1'b1;
        m_mar = opd;
        case (inst[DW-1:DW-4])
            4'h1: begin m_mbr = m_mem[opd]; m_ac = m_ac & m_mbr; m_zero = (m_ac == 0); end
            4'h2: begin m_ac = DW'(opd); m_zero = (m_ac == 0); end
            4'h3: begin m_mbr = m_mem[opd]; m_ac = m_mbr; m_zero = (m_ac == 0); end
            4'h5: begin
                m_mbr = m_mem[opd]; m_carry = (m_ac < m_mbr);
                m_ac = m_ac - m_mbr; m_zero = (m_ac == 0);
            end
            4'h7: begin
                m_mbr = m_mem[opd]; s = m_ac + m_mbr;
                m_ac = s[DW-1:0]; m_carry = s[DW]; m_zero = (m_ac == 0);
            end
            4'h8: m_pc = opd;
            4'h9: if (m_zero) m_pc = opd;
            4'hB: begin m_mbr = m_ac; m_mem[opd] = m_mbr; end
            4'hF: m_halted = 1'b1;
            default: ;
        endcase
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) m_mem[i] = '0;
    end

    always begin
        logic          do_cmp;
        logic [DW-1:0] w;
        @(posedge clock);
        do_cmp = 1'b0;
        if (reset) begin
            if (prog_we) m_mem[prog_addr] = prog_data;
            m_pc = 6'd10; m_ir = '0; m_mbr = '0; m_ac = '0; m_mar = '0;
            m_zero = 1'b1; m_carry = 1'b0; m_halted = 1'b0; m_cnt = 0;
            m_valid = 1'b1; do_cmp = 1'b1;
        end else if (m_valid) begin
            if (m_halted) begin
                if (prog_we) m_mem[prog_addr] = prog_data;
                if (resume) begin m_halted = 1'b0; m_cnt = 0; end
                do_cmp = 1'b1;
            end else begin
                m_cnt++;
                if (m_cnt == 1) begin
                    w = m_mem[m_pc];
                    m_lat = latency(w[DW-1:DW-4]);
                end
                if (m_cnt == m_lat) begin
                    model_exec();
                    m_cnt  = 0;
                    do_cmp = 1'b1;
                end
            end
        end
        #1;
        if (m_valid) chk("model halted", DW'(halted), DW'(m_halted));
        if (do_cmp) begin
            chk("model PC",    DW'(PC),    DW'(m_pc));
            chk("model IR",    IR,         m_ir);
            chk("model MBR",   MBR,        m_mbr);
            chk("model AC",    AC,         m_ac);
            chk("model MAR",   DW'(MAR),   DW'(m_mar));
            chk("model zero",  DW'(zero),  DW'(m_zero));
            chk("model carry", DW'(carry), DW'(m_carry));
        end
    end

    // ---------------- stimulus ----------------
    task automatic run(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        @(negedge clock);
        prog_we = 1'b0;
    endtask

    task automatic enter_reset();
        reset = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        @(negedge clock);

        // Legacy program
        enter_reset();
        chk("reset PC", DW'(PC), 16'd10);
        chk("reset zero", DW'(zero), 16'd1);
        load(10, 16'h3020); load(11, 16'h7021); load(12, 16'hB022); load(13, 16'hF000);
        load(32, 16'h0007); load(33, 16'h0005);
        reset = 1'b0;
        run(17);
        chk("legacy not yet halted", DW'(halted), 16'd0);
        run(1);
        chk("legacy halted@18", DW'(halted), 16'd1);
        chk("legacy AC", AC, 16'd12);
        chk("legacy mem34", dut.r_mem[34], 16'd12);
        chk("legacy carry", DW'(carry), 16'd0);
        chk("legacy zero", DW'(zero), 16'd0);

        // Overflow: ADD then SUB with carry/borrow
        enter_reset();
        load(10, 16'h3020); load(11, 16'h7021); load(12, 16'h5021); load(13, 16'hF000);
        load(32, 16'hFFFF); load(33, 16'h0002);
        reset = 1'b0;
        run(10);
        chk("ovf add AC", AC, 16'h0001);
        chk("ovf add carry", DW'(carry), 16'd1);
        chk("ovf add zero", DW'(zero), 16'd0);
        run(5);
        chk("ovf sub AC", AC, 16'hFFFF);
        chk("ovf sub borrow", DW'(carry), 16'd1);
        run(3);

        // Branch taken / not taken; stray prog_we and resume while running
        enter_reset();
        load(10, 16'h2000); load(11, 16'h9014); load(20, 16'h2001);
        load(21, 16'h901E); load(22, 16'hF000); load(50, 16'h1111);
        reset = 1'b0;
        run(1);
        prog_we = 1'b1; prog_addr = 6'd50; prog_data = 16'hABCD; resume = 1'b1;
        @(negedge clock);
        prog_we = 1'b0; resume = 1'b0;
        run(4);
        chk("jz taken PC", DW'(PC), 16'd20);
        chk("jz taken zero", DW'(zero), 16'd1);
        run(6);
        chk("jz fallthrough PC", DW'(PC), 16'd22);
        chk("jz fallthrough AC", AC, 16'd1);
        run(3);
        chk("running prog_we ignored", dut.r_mem[50], 16'h1111);

        // Halt / resume with a program write while halted
        enter_reset();
        load(10, 16'h0000); load(11, 16'h0000); load(12, 16'h0000);
        load(13, 16'hF000); load(14, 16'h0000); load(15, 16'hF000);
        reset = 1'b0;
        run(12);
        chk("halt reached", DW'(halted), 16'd1);
        chk("halt PC", DW'(PC), 16'd14);
        run(3);
        load(14, 16'h2003);
        run(6);
        chk("halt hold PC", DW'(PC), 16'd14);
        resume = 1'b1;
        @(negedge clock);
        resume = 1'b0;
        chk("resume clears halted", DW'(halted), 16'd0);
        run(3);
        chk("resume LOADI AC", AC, 16'd3);
        chk("resume PC", DW'(PC), 16'd15);
        run(3);
        chk("second halt", DW'(halted), 16'd1);

        // Reset during STORE write-back
        enter_reset();
        load(10, 16'h2009); load(11, 16'hB028); load(40, 16'h1234);
        reset = 1'b0;
        run(7);
        chk("store MBR before wb", MBR, 16'd9);
        reset = 1'b1;
        @(negedge clock);
        chk("midstore mem40", dut.r_mem[40], 16'h1234);
        chk("midstore PC", DW'(PC), 16'd10);
        chk("midstore IR", IR, 16'd0);
        chk("midstore MBR", MBR, 16'd0);
        chk("midstore AC", AC, 16'd0);
        chk("midstore MAR", DW'(MAR), 16'd0);
        chk("midstore zero", DW'(zero), 16'd1);
        chk("midstore carry", DW'(carry), 16'd0);

        // PC wrap on the RESET_PC=63 instance
        load(63, 16'h0000); load(0, 16'hF000);
        reset = 1'b0;
        chk("wrap reset PC", DW'(w_wrap_pc), 16'd63);
        run(3);
        chk("wrap PC", DW'(w_wrap_pc), 16'd0);
        run(3);
        chk("wrap halted", DW'(w_wrap_halted), 16'd1);
        chk("wrap PC after halt", DW'(w_wrap_pc), 16'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
